// File: rtl/ras_pkg.sv
// Shared types for the return-address-stack front-end controller.
package ras_pkg;

  typedef enum logic [1:0] {
    RAS_NONE,
    RAS_PUSH,
    RAS_POP,
    RAS_POPPUSH
  } ras_op_e;

  typedef enum logic {
    RUN,
    RECOVER
  } ras_ctrl_state_e;

  localparam logic [4:0] RAS_LINK_X1 = 5'd1;
  localparam logic [4:0] RAS_LINK_X5 = 5'd5;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  function automatic logic is_link(input logic [4:0] r);
    return (r == RAS_LINK_X1) || (r == RAS_LINK_X5);
  endfunction

endpackage

// File: rtl/ras_call_decode.sv
// Classifies one fetched instruction into a RAS operation.
// Compressed (16-bit) decoding is compiled in only when RAS_CTRL_RVC_EN is defined.
module ras_call_decode
  import ras_pkg::*;
(
  input  logic [31:0] instr_i,
  output ras_op_e     op_o,
  output logic        is_rvc_o
);

  logic [4:0] rd;
  logic [4:0] rs1;
  logic       rd_link;
  logic       rs1_link;
  logic       unused_bits;

  assign unused_bits = ^instr_i[31:20];

  always_comb begin
    op_o     = RAS_NONE;
    is_rvc_o = 1'b0;
    rd       = instr_i[11:7];
    rs1      = instr_i[19:15];
    rd_link  = is_link(rd);
    rs1_link = is_link(rs1);
    if (instr_i[1:0] == 2'b11) begin
      if (instr_i[6:0] == OPC_JAL) begin
        if (rd_link) op_o = RAS_PUSH;
      end else if (instr_i[6:0] == OPC_JALR && instr_i[14:12] == 3'b000) begin
        if (rd_link && !rs1_link)      op_o = RAS_PUSH;
        else if (rd_link && rs1_link)  op_o = (rd == rs1) ? RAS_PUSH : RAS_POPPUSH;
        else if (!rd_link && rs1_link) op_o = RAS_POP;
      end
    end
`ifdef RAS_CTRL_RVC_EN
    else begin
      is_rvc_o = 1'b1;
      // C.JAL (RV32) in quadrant 1; C.JR/C.JALR share funct3 100 in quadrant 2.
      if (instr_i[1:0] == 2'b01 && instr_i[15:13] == 3'b001) begin
        op_o = RAS_PUSH;
      end else if (instr_i[1:0] == 2'b10 && instr_i[15:13] == 3'b100 &&
                   instr_i[6:2] == 5'd0 && rd != 5'd0) begin
        if (instr_i[12])  op_o = (rd == RAS_LINK_X5) ? RAS_POPPUSH : RAS_PUSH;
        else if (rd_link) op_o = RAS_POP;
      end
    end
`endif
  end

endmodule

// File: rtl/ras_ctrl.sv
// RAS front-end controller: call/return decode, RAS push/pop, prediction capture and hit/miss stats.
// Optional compressed decode via RAS_CTRL_RVC_EN.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int STAGES     = 2,
  parameter int XLEN       = 32,
  parameter int WIDTH      = XLEN - 1,
  parameter int PEND_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  f_valid,
  output logic                  f_ready,
  input  logic [XLEN-1:0]       f_pc,
  input  logic [31:0]           f_instr,
  input  logic [STAGES-1:0]     adv_i,
  input  logic [STAGES-1:0]     kill_i,
  output logic                  ras_push,
  output logic                  ras_pop,
  output logic [WIDTH-1:0]      ras_din,
  output logic [STAGES-1:0]     ras_commit,
  output logic [STAGES-1:0]     ras_flush,
  input  logic [WIDTH-1:0]      ras_dout,
  input  logic                  ras_valid,
  output logic                  pred_valid,
  output logic [XLEN-1:0]       pred_target,
  input  logic                  resolve_valid,
  input  logic [XLEN-1:0]       resolve_target,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt,
  output ras_ctrl_state_e       state_o
);

  localparam int PTR_W = $clog2(PEND_DEPTH);

  ras_ctrl_state_e   state_q, state_d;
  ras_op_e           op_q, op_d, dec_op;
  logic              op_valid_q, op_valid_d;
  logic [WIDTH-1:0]  ras_din_q, ras_din_d;
  logic [PTR_W:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  hit_q, hit_d, miss_q, miss_d;
  logic [XLEN-1:0]   pend_mem [PEND_DEPTH];

  logic              dec_rvc;
  logic [XLEN-1:0]   ret_addr;
  logic              kill_any, accept, issue, pop_in_flight;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [PTR_W:0]    pend_cnt, occ;
  logic              unused_ret0;

  ras_call_decode u_dec (
    .instr_i  (f_instr),
    .op_o     (dec_op),
    .is_rvc_o (dec_rvc)
  );

  assign ret_addr    = f_pc + (dec_rvc ? XLEN'(2) : XLEN'(4));
  assign unused_ret0 = ret_addr[0];

  assign ras_commit = adv_i & ~kill_i;
  assign ras_flush  = kill_i;
  assign ras_din    = ras_din_q;
  assign hit_cnt    = hit_q;
  assign miss_cnt   = miss_q;
  assign state_o    = state_q;

  always_comb begin
    kill_any      = |kill_i;
    pend_cnt      = wr_q - rd_q;
    fifo_empty    = (pend_cnt == '0);
    pop_in_flight = op_valid_q && (op_q == RAS_POP || op_q == RAS_POPPUSH);
    // An in-flight return will occupy a slot next cycle, so reserve it now.
    occ           = pend_cnt + {{PTR_W{1'b0}}, pop_in_flight};
    f_ready       = !rst_i && (state_q == RUN) && (occ < (PTR_W+1)'(PEND_DEPTH));
    accept        = f_valid && f_ready;

    issue       = op_valid_q && !kill_any && !rst_i;
    ras_push    = issue && (op_q == RAS_PUSH || op_q == RAS_POPPUSH);
    ras_pop     = issue && (op_q == RAS_POP  || op_q == RAS_POPPUSH);
    pred_valid  = ras_pop && ras_valid;
    pred_target = {ras_dout, 1'b0};

    op_valid_d = accept && !kill_any && (dec_op != RAS_NONE);
    op_d       = accept ? dec_op : op_q;
    ras_din_d  = accept ? ret_addr[XLEN-1:1] : ras_din_q;

    fifo_push = pred_valid;
    fifo_pop  = resolve_valid && !fifo_empty;
    wr_d      = fifo_push ? wr_q + 1'b1 : wr_q;
    rd_d      = fifo_pop  ? rd_q + 1'b1 : rd_q;
    if (kill_any) begin
      wr_d = '0;
      rd_d = '0;
    end

    hit_d  = hit_q;
    miss_d = miss_q;
    if (fifo_pop) begin
      if (pend_mem[rd_q[PTR_W-1:0]] == resolve_target) begin
        if (hit_q != '1) hit_d = hit_q + 1'b1;
      end else begin
        if (miss_q != '1) miss_d = miss_q + 1'b1;
      end
    end

    state_d = state_q;
    case (state_q)
      RUN:     if (kill_any)  state_d = RECOVER;
      RECOVER: if (!kill_any) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= RUN;
      op_q       <= RAS_NONE;
      op_valid_q <= 1'b0;
      ras_din_q  <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      op_valid_q <= op_valid_d;
      ras_din_q  <= ras_din_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) pend_mem[wr_q[PTR_W-1:0]] <= pred_target;
  end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: decode, prediction, statistics, back-pressure, kill and reset.
module tb_ras_ctrl;
  import ras_pkg::*;

  localparam int STAGES = 2;
  localparam int XLEN   = 32;
  localparam int WIDTH  = 31;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  localparam logic [31:0] I_JAL_X1 = 32'h0000_00EF;
  localparam logic [31:0] I_RET    = 32'h0000_8067;
  localparam logic [31:0] I_CORO   = 32'h0002_80E7;
  localparam logic [31:0] I_NOP    = 32'h0000_0013;
  localparam logic [31:0] I_CJALR  = 32'h0000_9082;

  logic              clk;
  logic              rst_i;
  logic              f_valid;
  logic              f_ready;
  logic [XLEN-1:0]   f_pc;
  logic [31:0]       f_instr;
  logic [STAGES-1:0] adv_i;
  logic [STAGES-1:0] kill_i;
  logic              ras_push;
  logic              ras_pop;
  logic [WIDTH-1:0]  ras_din;
  logic [STAGES-1:0] ras_commit;
  logic [STAGES-1:0] ras_flush;
  logic [WIDTH-1:0]  ras_dout;
  logic              ras_valid;
  logic              pred_valid;
  logic [XLEN-1:0]   pred_target;
  logic              resolve_valid;
  logic [XLEN-1:0]   resolve_target;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;
  ras_ctrl_state_e   state_o;

  int n_checks = 0;
  int n_fail   = 0;

  ras_ctrl #(
    .STAGES(STAGES), .XLEN(XLEN), .WIDTH(WIDTH), .PEND_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_instr(f_instr),
    .adv_i(adv_i), .kill_i(kill_i),
    .ras_push(ras_push), .ras_pop(ras_pop), .ras_din(ras_din),
    .ras_commit(ras_commit), .ras_flush(ras_flush),
    .ras_dout(ras_dout), .ras_valid(ras_valid),
    .pred_valid(pred_valid), .pred_target(pred_target),
    .resolve_valid(resolve_valid), .resolve_target(resolve_target),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; f_valid = 1'b0; f_pc = '0; f_instr = I_NOP;
    adv_i = 2'b11; kill_i = 2'b10; ras_dout = '0; ras_valid = 1'b0;
    resolve_valid = 1'b0; resolve_target = '0;

    // Reset values
    tick(); tick(); #1;
    check("rst_f_ready", 32'(f_ready), 0);
    check("rst_push", 32'(ras_push), 0);
    check("rst_pop", 32'(ras_pop), 0);
    check("rst_din", 32'(ras_din), 0);
    check("rst_pred", 32'(pred_valid), 0);
    check("rst_hit", 32'(hit_cnt), 0);
    check("rst_miss", 32'(miss_cnt), 0);
    check("rst_flush", 32'(ras_flush), 32'h2);
    check("rst_commit", 32'(ras_commit), 32'h1);
    rst_i = 1'b0; kill_i = '0; adv_i = '0; #1;
    check("post_rst_f_ready", 32'(f_ready), 1);
    check("post_rst_state", 32'(state_o), 32'(RUN));

    // Call: JAL x1 at 0x1000
    f_valid = 1'b1; f_instr = I_JAL_X1; f_pc = 32'h1000;
    tick(); f_valid = 1'b0; f_instr = I_NOP; #1;
    check("call_push", 32'(ras_push), 1);
    check("call_pop", 32'(ras_pop), 0);
    check("call_din", 32'(ras_din), 32'h802);
    check("call_pred", 32'(pred_valid), 0);
    tick(); #1;
    check("call_push_1cyc", 32'(ras_push), 0);

    // Return with valid TOS, then a hit
    f_valid = 1'b1; f_instr = I_RET; f_pc = 32'h1100;
    tick(); f_valid = 1'b0; ras_dout = 31'h802; ras_valid = 1'b1; #1;
    check("ret_pop", 32'(ras_pop), 1);
    check("ret_push", 32'(ras_push), 0);
    check("ret_pred", 32'(pred_valid), 1);
    check("ret_target", pred_target, 32'h1004);
    tick(); resolve_valid = 1'b1; resolve_target = 32'h1004; #1;
    check("ret_pop_1cyc", 32'(ras_pop), 0);
    tick(); resolve_valid = 1'b0; #1;
    check("hit1_hit", 32'(hit_cnt), 1);
    check("hit1_miss", 32'(miss_cnt), 0);

    // Second return mispredicted
    f_valid = 1'b1; f_instr = I_RET;
    tick(); f_valid = 1'b0; ras_dout = 31'h900; #1;
    check("ret2_target", pred_target, 32'h1200);
    tick(); resolve_valid = 1'b1; resolve_target = 32'h2000;
    tick(); resolve_valid = 1'b0; #1;
    check("miss1_miss", 32'(miss_cnt), 1);
    check("miss1_hit", 32'(hit_cnt), 1);

    // Coroutine JALR x1,0(x5)
    f_valid = 1'b1; f_instr = I_CORO; f_pc = 32'h3000;
    tick(); f_valid = 1'b0; ras_dout = 31'h802; #1;
    check("coro_push", 32'(ras_push), 1);
    check("coro_pop", 32'(ras_pop), 1);
    check("coro_din", 32'(ras_din), 32'h1802);
    check("coro_pred", 32'(pred_valid), 1);
    tick(); resolve_valid = 1'b1; resolve_target = 32'h1004;
    tick(); resolve_valid = 1'b0; #1;
    check("coro_hit", 32'(hit_cnt), 2);

    // Return on an empty RAS: no prediction, later resolve is ignored
    ras_valid = 1'b0;
    f_valid = 1'b1; f_instr = I_RET;
    tick(); f_valid = 1'b0; #1;
    check("empty_pop", 32'(ras_pop), 1);
    check("empty_pred", 32'(pred_valid), 0);
    tick(); resolve_valid = 1'b1; resolve_target = 32'h1004;
    tick(); resolve_valid = 1'b0; #1;
    check("empty_res_hit", 32'(hit_cnt), 2);
    check("empty_res_miss", 32'(miss_cnt), 1);

    // Back-pressure: four outstanding returns fill the pending FIFO
    ras_valid = 1'b1; ras_dout = 31'h802;
    f_valid = 1'b1; f_instr = I_RET; #1;
    check("full_c0_ready", 32'(f_ready), 1);
    tick(); check("full_c1_ready", 32'(f_ready), 1);
    tick(); check("full_c2_ready", 32'(f_ready), 1);
    tick(); check("full_c3_ready", 32'(f_ready), 1);
    tick();
    check("full_c4_ready", 32'(f_ready), 0);
    check("full_c4_pred", 32'(pred_valid), 1);
    tick();
    check("full_c5_ready", 32'(f_ready), 0);
    check("full_c5_pred", 32'(pred_valid), 0);
    resolve_valid = 1'b1; resolve_target = 32'h1004;
    tick(); resolve_valid = 1'b0; #1;
    check("full_c6_ready", 32'(f_ready), 1);
    tick(); f_valid = 1'b0; #1;
    check("full_c7_pred", 32'(pred_valid), 1);
    resolve_valid = 1'b1;
    tick(); tick(); tick(); tick(); resolve_valid = 1'b0; #1;
    check("drain_hit_sat", 32'(hit_cnt), 7);
    check("drain_ready", 32'(f_ready), 1);

    // Kill the cycle after a call is accepted, with one prediction pending
    f_valid = 1'b1; f_instr = I_RET; f_pc = 32'h5000;
    tick(); f_instr = I_JAL_X1; f_pc = 32'h4000; #1;
    check("kill_pre_pred", 32'(pred_valid), 1);
    tick(); f_valid = 1'b0; f_instr = I_NOP; kill_i = 2'b01; adv_i = 2'b11; #1;
    check("kill_push", 32'(ras_push), 0);
    check("kill_flush", 32'(ras_flush), 32'h1);
    check("kill_commit", 32'(ras_commit), 32'h2);
    tick(); kill_i = '0; adv_i = '0; #1;
    check("recover_ready", 32'(f_ready), 0);
    check("recover_state", 32'(state_o), 32'(RECOVER));
    check("recover_push", 32'(ras_push), 0);
    tick(); #1;
    check("run_ready", 32'(f_ready), 1);
    resolve_valid = 1'b1; resolve_target = 32'h1234;
    tick(); resolve_valid = 1'b0; #1;
    check("kill_fifo_miss", 32'(miss_cnt), 1);
    check("kill_fifo_hit", 32'(hit_cnt), 7);

    // Hit counter saturates
    f_valid = 1'b1; f_instr = I_RET;
    tick(); f_valid = 1'b0; #1;
    check("sat_pred", 32'(pred_valid), 1);
    tick(); resolve_valid = 1'b1; resolve_target = 32'h1004;
    tick(); resolve_valid = 1'b0; #1;
    check("sat_hit", 32'(hit_cnt), 7);
    check("sat_miss", 32'(miss_cnt), 1);

    // Compressed C.JALR x1 at 0x2000
    f_valid = 1'b1; f_instr = I_CJALR; f_pc = 32'h2000;
    tick(); f_valid = 1'b0; f_instr = I_NOP; #1;
`ifdef RAS_CTRL_RVC_EN
    check("rvc_push", 32'(ras_push), 1);
    check("rvc_din", 32'(ras_din), 32'h1001);
`else
    check("rvc_off_push", 32'(ras_push), 0);
    check("rvc_off_pop", 32'(ras_pop), 0);
`endif
    tick();

    // Reset mid-operation
    f_valid = 1'b1; f_instr = I_RET;
    tick(); f_instr = I_JAL_X1; #1;
    check("midrst_pred", 32'(pred_valid), 1);
    tick(); f_valid = 1'b0; f_instr = I_NOP; rst_i = 1'b1; #1;
    check("midrst_push", 32'(ras_push), 0);
    tick(); rst_i = 1'b0; #1;
    check("midrst_hit", 32'(hit_cnt), 0);
    check("midrst_miss", 32'(miss_cnt), 0);
    check("midrst_push_after", 32'(ras_push), 0);
    check("midrst_ready", 32'(f_ready), 1);
    resolve_valid = 1'b1; resolve_target = 32'h1004;
    tick(); resolve_valid = 1'b0; #1;
    check("midrst_fifo_hit", 32'(hit_cnt), 0);
    check("midrst_fifo_miss", 32'(miss_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
